// File: rtl/btn_debounce_array.sv
// N-channel button conditioner: two-flop synchroniser, debounce counter,
// registered press/release pulses and per-channel auto-repeat.
// Channels are independent copies of the same logic.
module btn_debounce_array #(
    parameter int unsigned N             = 5,
    parameter int unsigned STABLE_CYCLES = 131072,
    parameter int unsigned REPEAT_DELAY  = 2500000,
    parameter int unsigned REPEAT_RATE   = 500000,
    parameter bit          INVERT        = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_repeat
);

    localparam int unsigned SW   = $clog2(STABLE_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_RATE
    } rpt_state_t;

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;

    // Two-flop synchroniser for the (optionally inverted) raw inputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_in ^ {N{INVERT}};
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [SW-1:0] r_scnt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;
        logic [RW-1:0] r_rcnt;
        rpt_state_t    r_state;

        logic w_flip;
        logic w_level_nxt;
        logic w_rise;
        logic w_fall;

        // The repeat FSM reacts to the level change on the same edge it happens,
        // so the press pulse and the DELAY entry line up in the same cycle.
        assign w_flip      = (r_s2[g] != r_level) && (r_scnt == S_LAST);
        assign w_level_nxt = w_flip ? r_s2[g] : r_level;
        assign w_rise      = w_flip & r_s2[g];
        assign w_fall      = w_flip & ~r_s2[g];

        // Debounce: level flips only after STABLE_CYCLES consecutive differing samples
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_scnt    <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (r_s2[g] == r_level) begin
                    r_scnt <= '0;
                end else if (r_scnt == S_LAST) begin
                    r_level <= r_s2[g];
                    r_scnt  <= '0;
                end else begin
                    r_scnt <= r_scnt + 1'b1;
                end
            end
        end

        // Auto-repeat FSM: delay before the first pulse, then a fixed rate while held
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state  <= RPT_IDLE;
                r_rcnt   <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_repeat <= 1'b0;
                if (!repeat_en[g] || w_fall) begin
                    r_state <= RPT_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    case (r_state)
                        RPT_IDLE: begin
                            // Covers both a fresh press and re-enable while held
                            if (w_level_nxt) begin
                                r_state <= RPT_DELAY;
                                r_rcnt  <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (r_rcnt == D_LAST) begin
                                r_repeat <= 1'b1;
                                r_rcnt   <= '0;
                                r_state  <= RPT_RATE;
                            end else begin
                                r_rcnt <= r_rcnt + 1'b1;
                            end
                        end
                        RPT_RATE: begin
                            if (r_rcnt == R_LAST) begin
                                r_repeat <= 1'b1;
                                r_rcnt   <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state <= RPT_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign btn_repeat[g]  = r_repeat;
    end

endmodule
